// File: rtl/micro_hash_pkg.sv
// micro_hash_pkg: shared definition of the 24-bit micro-hash.
// Holds the initial hash words, round constants, round count, the checker FSM
// state type and the single-round function. The miner's hash core and the
// nonce checker both import this package, so the hash is defined only here.
package micro_hash_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ROUNDS   = 32;
    localparam int unsigned K_SWITCH = 16;

    localparam logic [7:0] H_INIT0 = 8'h01;
    localparam logic [7:0] H_INIT1 = 8'h89;
    localparam logic [7:0] H_INIT2 = 8'hFE;
    localparam logic [7:0] K_LO    = 8'h99;
    localparam logic [7:0] K_HI    = 8'hA1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StDone  = 2'd2
    } state_e;

    // One compression round. h = {H0,H1,H2}, wi = schedule byte, i = round index.
    // Returns the next {H0,H1,H2}; all arithmetic wraps mod 256.
    function automatic logic [23:0] hash_round(input logic [23:0] h,
                                               input logic [7:0]  wi,
                                               input logic [4:0]  i);
        logic [7:0] h0, h1, h2, k, x, t;
        h0 = h[23:16];
        h1 = h[15:8];
        h2 = h[7:0];
        // Rounds 0..16 inclusive use the low constant and mix H1/H2.
        if (i <= 5'(K_SWITCH)) begin
            k = K_LO;
            x = h1 ^ h2;
        end else begin
            k = K_HI;
            x = h0 ^ h1;
        end
        t = x + k + wi;
        return {h1 ^ t, {h2[6:0], h2[7]}, 8'(h0 + t)};
    endfunction

endpackage

// File: rtl/micro_hash_round.sv
// micro_hash_round: combinational micro-hash round plus message-window feedback.
// Ports:
//   h_i      current {H0,H1,H2}
//   w0_i     schedule byte used by this round (window slot 0)
//   w2_i, w7_i, w13_i  window slots feeding the next schedule byte
//   round_i  round index 0..31
//   h_o      next {H0,H1,H2}
//   w_fb_o   byte shifted into window slot 15
module micro_hash_round
    import micro_hash_pkg::*;
(
    input  logic [23:0] h_i,
    input  logic [7:0]  w0_i,
    input  logic [7:0]  w2_i,
    input  logic [7:0]  w7_i,
    input  logic [7:0]  w13_i,
    input  logic [4:0]  round_i,
    output logic [23:0] h_o,
    output logic [7:0]  w_fb_o
);

    assign h_o    = hash_round(h_i, w0_i, round_i);
    assign w_fb_o = w13_i | (w7_i ^ w2_i);

endmodule

// File: rtl/nonce_checker.sv
// nonce_checker: independent verifier for a miner's nonce.
// Captures a 96-bit header, a 32-bit nonce and an 8-bit target, runs the
// 32-round micro-hash one round per clock, then presents the final hash, the
// echoed nonce and a pass flag (H0 < target and H1 < target) with a
// valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready only while idle)
//   data_in    header bytes B0..B11, B0 = data_in[95:88]
//   nonce_in   bytes B12..B15, B12 = nonce_in[31:24]
//   target     difficulty captured with the request
//   out_valid / out_ready  result handshake
//   nonce_ok, nonce_out, hash_out  result fields, held after the handshake
// Optional build macro NONCE_CHECKER_STATS_EN adds saturating checked_cnt and
// passed_cnt result counters.
module nonce_checker
    import micro_hash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] data_in,
    input  logic [31:0] nonce_in,
    input  logic [7:0]  target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        nonce_ok,
    output logic [31:0] nonce_out,
    output logic [23:0] hash_out
`ifdef NONCE_CHECKER_STATS_EN
    ,
    output logic [15:0] checked_cnt,
    output logic [15:0] passed_cnt
`endif
);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [23:0]       h_q, h_d;
    logic [15:0][7:0]  w_q, w_d;
    logic [7:0]        tgt_q, tgt_d;
    logic [31:0]       nonce_q, nonce_d;
    logic [23:0]       hash_out_q, hash_out_d;
    logic              nonce_ok_q, nonce_ok_d;
    logic [31:0]       nonce_out_q, nonce_out_d;

    logic [23:0]       h_next;
    logic [7:0]        w_fb;

    micro_hash_round u_round (
        .h_i     (h_q),
        .w0_i    (w_q[0]),
        .w2_i    (w_q[2]),
        .w7_i    (w_q[7]),
        .w13_i   (w_q[13]),
        .round_i (cnt_q),
        .h_o     (h_next),
        .w_fb_o  (w_fb)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        w_d         = w_q;
        tgt_d       = tgt_q;
        nonce_d     = nonce_q;
        hash_out_d  = hash_out_q;
        nonce_ok_d  = nonce_ok_q;
        nonce_out_d = nonce_out_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    for (int j = 0; j < 12; j++) begin
                        w_d[j] = data_in[95 - 8*j -: 8];
                    end
                    for (int j = 0; j < 4; j++) begin
                        w_d[12 + j] = nonce_in[31 - 8*j -: 8];
                    end
                    h_d     = {H_INIT0, H_INIT1, H_INIT2};
                    tgt_d   = target;
                    nonce_d = nonce_in;
                    cnt_d   = '0;
                    state_d = StRound;
                end
            end
            StRound: begin
                h_d = h_next;
                w_d = {w_fb, w_q[15:1]};
                if (cnt_q == 5'(ROUNDS - 1)) begin
                    // Last round: publish from the next-state hash; cnt stays at 31.
                    hash_out_d  = h_next;
                    nonce_ok_d  = (h_next[23:16] < tgt_q) && (h_next[15:8] < tgt_q);
                    nonce_out_d = nonce_q;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            h_q         <= '0;
            w_q         <= '0;
            tgt_q       <= '0;
            nonce_q     <= '0;
            hash_out_q  <= '0;
            nonce_ok_q  <= 1'b0;
            nonce_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            w_q         <= w_d;
            tgt_q       <= tgt_d;
            nonce_q     <= nonce_d;
            hash_out_q  <= hash_out_d;
            nonce_ok_q  <= nonce_ok_d;
            nonce_out_q <= nonce_out_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign nonce_ok  = nonce_ok_q;
    assign nonce_out = nonce_out_q;
    assign hash_out  = hash_out_q;

`ifdef NONCE_CHECKER_STATS_EN
    logic [15:0] checked_q, checked_d;
    logic [15:0] passed_q, passed_d;
    logic        res_hs;

    assign res_hs = (state_q == StDone) && out_ready;

    always_comb begin
        checked_d = checked_q;
        passed_d  = passed_q;
        if (res_hs) begin
            if (checked_q != 16'hFFFF) checked_d = checked_q + 16'd1;
            if (nonce_ok_q && (passed_q != 16'hFFFF)) passed_d = passed_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checked_q <= '0;
            passed_q  <= '0;
        end else begin
            checked_q <= checked_d;
            passed_q  <= passed_d;
        end
    end

    assign checked_cnt = checked_q;
    assign passed_cnt  = passed_q;
`endif

endmodule

// File: tb/tb_nonce_checker.sv
// tb_nonce_checker: self-checking bench for nonce_checker.
// Expected results come from a direct model of the hash: full 48-entry
// schedule array, then 32 rounds in integer arithmetic.
module tb_nonce_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] data_in;
    logic [31:0] nonce_in;
    logic [7:0]  target;
    logic        out_valid;
    logic        out_ready;
    logic        nonce_ok;
    logic [31:0] nonce_out;
    logic [23:0] hash_out;
`ifdef NONCE_CHECKER_STATS_EN
    logic [15:0] checked_cnt;
    logic [15:0] passed_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_checked = 0;
    int exp_passed  = 0;

    localparam logic [95:0] HDR_A = 96'h397d9f2f40ca9e6c6b1f3324;
    localparam logic [95:0] HDR_B = 96'h3c87edfd24331f6b6c9eca40;

    nonce_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .nonce_in  (nonce_in),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nonce_ok  (nonce_ok),
        .nonce_out (nonce_out),
        .hash_out  (hash_out)
`ifdef NONCE_CHECKER_STATS_EN
        ,
        .checked_cnt (checked_cnt),
        .passed_cnt  (passed_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [95:0] data;
        logic [31:0] nonce;
        logic [7:0]  tgt;
        logic [23:0] exp_hash;
        logic        exp_ok;
        int          hold;
    } vec_t;

    function automatic logic [23:0] model_hash(input logic [95:0] d, input logic [31:0] n);
        int          w[48];
        logic [127:0] blk;
        int h0, h1, h2, nh0, nh1, nh2, k, x, t;
        blk = {d, n};
        for (int i = 0; i < 16; i++) w[i] = int'(blk[127 - 8*i -: 8]);
        for (int i = 16; i < 48; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        h0 = 1; h1 = 137; h2 = 254;
        for (int i = 0; i < 32; i++) begin
            k   = (i <= 16) ? 153 : 161;
            x   = (i <= 16) ? (h1 ^ h2) : (h0 ^ h1);
            t   = (x + k + w[i]) % 256;
            nh0 = h1 ^ t;
            nh1 = ((h2 * 2) % 256) + (h2 / 128);
            nh2 = (h0 + t) % 256;
            h0 = nh0; h1 = nh1; h2 = nh2;
        end
        return {8'(h0), 8'(h1), 8'(h2)};
    endfunction

    function automatic logic model_ok(input logic [23:0] h, input logic [7:0] t);
        return (int'(h[23:16]) < int'(t)) && (int'(h[15:8]) < int'(t));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full request: accept, count latency, check result, hold, handshake.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        data_in  = v.data;
        nonce_in = v.nonce;
        target   = v.tgt;
        in_valid = 1'b1;
        chk({v.name, " in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            // Scrambled inputs during the rounds must be ignored.
            in_valid = 1'($urandom);
            data_in  = {$urandom, $urandom, $urandom};
            nonce_in = $urandom;
            target   = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({v.name, " latency"}, 32'(lat), 32'd32);
        chk({v.name, " hash"}, 32'(hash_out), 32'(v.exp_hash));
        chk({v.name, " ok"}, 32'(nonce_ok), 32'(v.exp_ok));
        chk({v.name, " nonce"}, nonce_out, v.nonce);
        chk({v.name, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int c = 0; c < v.hold; c++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk({v.name, " hold"}, {5'd0, out_valid, in_ready, nonce_ok, hash_out},
                {5'd0, 1'b1, 1'b0, v.exp_ok, v.exp_hash});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_checked++;
        if (v.exp_ok) exp_passed++;
        chk({v.name, " after_hs"}, {6'd0, out_valid, in_ready, hash_out},
            {6'd0, 1'b0, 1'b1, v.exp_hash});
    endtask

    vec_t vecs[5];
    vec_t rv;
    int   seen;
    logic [31:0] good_nonce;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        nonce_in  = '0;
        target    = '0;

        // Find a nonce that passes target 150 under the model.
        good_nonce = 32'd0;
        for (int n = 0; n < 1000; n++) begin
            if (model_ok(model_hash(HDR_A, 32'(n)), 8'd150)) begin
                good_nonce = 32'(n);
                break;
            end
        end

        vecs[0] = '{"pass150", HDR_A, good_nonce, 8'd150, model_hash(HDR_A, good_nonce), 1'b1, 2};
        vecs[1] = '{"tgt0", HDR_A, 32'd0, 8'd0, model_hash(HDR_A, 32'd0), 1'b0, 0};
        vecs[2] = '{"tgtFF", HDR_A, 32'd0, 8'hFF, model_hash(HDR_A, 32'd0),
                    model_ok(model_hash(HDR_A, 32'd0), 8'hFF), 1};
        vecs[3] = '{"backpressure", HDR_B, 32'hdeadbeef, 8'd128, model_hash(HDR_B, 32'hdeadbeef),
                    model_ok(model_hash(HDR_B, 32'hdeadbeef), 8'd128), 20};
        vecs[4] = '{"ones", HDR_A, 32'hffffffff, 8'd1, model_hash(HDR_A, 32'hffffffff),
                    model_ok(model_hash(HDR_A, 32'hffffffff), 8'd1), 3};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hash", 32'(hash_out), 32'd0);
        chk("rst_ok", 32'(nonce_ok), 32'd0);
        chk("rst_nonce", nonce_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // out_ready while idle has no effect.
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Randomized requests against the model.
        for (int i = 0; i < 8; i++) begin
            rv.name     = "random";
            rv.data     = {$urandom, $urandom, $urandom};
            rv.nonce    = $urandom;
            rv.tgt      = 8'($urandom_range(0, 255));
            rv.exp_hash = model_hash(rv.data, rv.nonce);
            rv.exp_ok   = model_ok(rv.exp_hash, rv.tgt);
            rv.hold     = int'($urandom_range(0, 3));
            run_vec(rv);
        end

        // Reset mid-round: partial result discarded, outputs back to reset values.
        @(negedge clk);
        data_in  = HDR_A;
        nonce_in = good_nonce;
        target   = 8'd150;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        exp_checked = 0;
        exp_passed  = 0;
        chk("midrst_outputs", {5'd0, out_valid, in_ready, nonce_ok, hash_out},
            {5'd0, 1'b0, 1'b1, 1'b0, 24'd0});
        chk("midrst_nonce", nonce_out, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);

        rv.name     = "after_reset";
        rv.data     = HDR_B;
        rv.nonce    = 32'h12345678;
        rv.tgt      = 8'd200;
        rv.exp_hash = model_hash(HDR_B, 32'h12345678);
        rv.exp_ok   = model_ok(rv.exp_hash, 8'd200);
        rv.hold     = 1;
        run_vec(rv);

`ifdef NONCE_CHECKER_STATS_EN
        chk("stats_checked", 32'(checked_cnt), 32'(exp_checked));
        chk("stats_passed", 32'(passed_cnt), 32'(exp_passed));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
